// File: rtl/dram_fifo_ctrl.sv
// Controller for the 2-wide dram_fifo write buffer: round-robin enqueue arbitration and a drain FSM for the pair/flush sequence.
// Optional statistics counters are compiled in when DRAM_FIFO_CTRL_STAT_EN is defined.
module dram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int TIMEOUT    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_valid,
    input  logic [DATA_WIDTH-1:0]     a_data,
    output logic                      a_ready,
    input  logic                      b_valid,
    input  logic [DATA_WIDTH-1:0]     b_data,
    output logic                      b_ready,
    input  logic                      flush_req,
    output logic [1:0]                fifo_enq_en,
    output logic [2*DATA_WIDTH-1:0]   fifo_enq_data,
    output logic [1:0]                fifo_deq_en,
    output logic [1:0]                fifo_inv_en,
    input  logic [2*DATA_WIDTH-1:0]   fifo_deq_data,
    input  logic                      fifo_full,
    output logic                      out_valid,
    output logic [1:0]                out_cnt,
    output logic [2*DATA_WIDTH-1:0]   out_data,
    input  logic                      out_ready,
`ifdef DRAM_FIFO_CTRL_STAT_EN
    output logic [31:0]               stat_acc_words,
    output logic [31:0]               stat_stall_cycles,
`endif
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] CAP = CW'(DEPTH - 2);

    typedef enum logic [1:0] {IDLE, HOLD, PAIR, FLUSH} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         count, count_next, slots;
    logic [TW-1:0]         timer, timer_next;
    logic                  rr, rr_next;
    logic                  grant_a, grant_b, hs;
    logic [1:0]            n_acc, n_pop;
    logic [DATA_WIDTH-1:0] lane0, lane1;

    // Two slots are kept in reserve, so admission is judged on the committed count alone.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        slots   = CAP - count;
        grant_a = 1'b0;
        grant_b = 1'b0;
        rr_next = rr;
        if (reset && !fifo_full) begin
            if (a_valid && b_valid) begin
                if (slots >= CW'(2)) begin
                    grant_a = 1'b1;
                    grant_b = 1'b1;
                    rr_next = ~rr;
                end else if (slots == CW'(1)) begin
                    grant_a = ~rr;
                    grant_b = rr;
                    rr_next = ~rr;
                end
            end else if (a_valid && slots != '0) begin
                grant_a = 1'b1;
                rr_next = 1'b1;
            end else if (b_valid && slots != '0) begin
                grant_b = 1'b1;
                rr_next = 1'b0;
            end
        end
    end

    always_comb begin
        lane0 = '0;
        lane1 = '0;
        if (grant_a && grant_b) begin
            lane0 = rr ? b_data : a_data;
            lane1 = rr ? a_data : b_data;
        end else if (grant_a) begin
            lane0 = a_data;
        end else if (grant_b) begin
            lane0 = b_data;
        end
    end

    assign a_ready       = grant_a;
    assign b_ready       = grant_b;
    assign fifo_enq_en   = {grant_a & grant_b, grant_a | grant_b};
    assign fifo_enq_data = {lane1, lane0};
    assign n_acc         = {1'b0, grant_a} + {1'b0, grant_b};

    assign out_valid   = (state == PAIR) || (state == FLUSH);
    assign out_cnt     = (state == PAIR) ? 2'd2 : (state == FLUSH) ? 2'd1 : 2'd0;
    assign out_data    = fifo_deq_data;
    assign hs          = out_valid && out_ready;
    assign n_pop       = hs ? out_cnt : 2'd0;
    assign fifo_inv_en = hs ? ((out_cnt == 2'd2) ? 2'b11 : 2'b01) : 2'b00;
    assign fifo_deq_en = {out_cnt == 2'd2, out_valid};
    assign count_next  = count + CW'(n_acc) - CW'(n_pop);
    assign occupancy   = count;

    // A FLUSH offer is held until taken so out_cnt never changes under a stalled handshake.
    always_comb begin
        state_next = state;
        timer_next = '0;
        if (state == FLUSH && !hs) begin
            state_next = FLUSH;
        end else if (count_next == '0) begin
            state_next = IDLE;
        end else if (count_next == CW'(1)) begin
            if (flush_req || TIMEOUT == 0 ||
                (state == HOLD && timer + TW'(1) == TW'(TIMEOUT))) begin
                state_next = FLUSH;
            end else begin
                state_next = HOLD;
                timer_next = (state == HOLD) ? timer + TW'(1) : '0;
            end
        end else begin
            state_next = PAIR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            timer <= '0;
            rr    <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            timer <= timer_next;
            rr    <= rr_next;
        end
    end

`ifdef DRAM_FIFO_CTRL_STAT_EN
    logic        stall;
    logic [32:0] acc_sum;

    assign stall   = (a_valid && !a_ready) || (b_valid && !b_ready);
    assign acc_sum = {1'b0, stat_acc_words} + 33'(n_acc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_acc_words    <= '0;
            stat_stall_cycles <= '0;
        end else begin
            stat_acc_words <= acc_sum[32] ? '1 : acc_sum[31:0];
            if (stall && stat_stall_cycles != '1)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dram_fifo_ctrl.sv
// Self-checking bench for dram_fifo_ctrl: a queue-based dram_fifo stand-in plus a word-level reference model.
module tb_dram_fifo_ctrl;

    localparam int DW      = 32;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          a_valid, b_valid, out_ready, flush_req;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready;
    logic [1:0]    fifo_enq_en, fifo_deq_en, fifo_inv_en;
    logic [2*DW-1:0] fifo_enq_data, fifo_deq_data, out_data;
    logic          fifo_full;
    logic          out_valid;
    logic [1:0]    out_cnt;
    logic [CW-1:0] occupancy;

    // Second controller with TIMEOUT = 0; its FIFO data path is not modelled.
    logic          a_valid0, out_ready0;
    logic          a_ready0, b_ready0, out_valid0;
    logic [1:0]    enq_en0, deq_en0, inv_en0, out_cnt0;
    logic [2*DW-1:0] enq_data0, out_data0;
    logic [CW-1:0] occupancy0;

`ifdef DRAM_FIFO_CTRL_STAT_EN
    logic [31:0] stat_acc, stat_stall, stat_acc0, stat_stall0;
`endif

    always #5 clk = ~clk;

    dram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .flush_req(flush_req),
        .fifo_enq_en(fifo_enq_en), .fifo_enq_data(fifo_enq_data),
        .fifo_deq_en(fifo_deq_en), .fifo_inv_en(fifo_inv_en),
        .fifo_deq_data(fifo_deq_data), .fifo_full(fifo_full),
        .out_valid(out_valid), .out_cnt(out_cnt), .out_data(out_data),
        .out_ready(out_ready),
`ifdef DRAM_FIFO_CTRL_STAT_EN
        .stat_acc_words(stat_acc), .stat_stall_cycles(stat_stall),
`endif
        .occupancy(occupancy)
    );

    dram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset),
        .a_valid(a_valid0), .a_data(32'h1234_5678), .a_ready(a_ready0),
        .b_valid(1'b0), .b_data(32'h0), .b_ready(b_ready0),
        .flush_req(1'b0),
        .fifo_enq_en(enq_en0), .fifo_enq_data(enq_data0),
        .fifo_deq_en(deq_en0), .fifo_inv_en(inv_en0),
        .fifo_deq_data('0), .fifo_full(1'b0),
        .out_valid(out_valid0), .out_cnt(out_cnt0), .out_data(out_data0),
        .out_ready(out_ready0),
`ifdef DRAM_FIFO_CTRL_STAT_EN
        .stat_acc_words(stat_acc0), .stat_stall_cycles(stat_stall0),
`endif
        .occupancy(occupancy0)
    );

    // dram_fifo stand-in: pops then pushes at the edge; head words are visible the next cycle.
    logic [DW-1:0] fq[$];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fq.delete();
        end else begin
            if (fifo_inv_en[0] && fq.size() > 0) void'(fq.pop_front());
            if (fifo_inv_en[1] && fq.size() > 0) void'(fq.pop_front());
            if (fifo_enq_en[0]) fq.push_back(fifo_enq_data[DW-1:0]);
            if (fifo_enq_en[1]) fq.push_back(fifo_enq_data[2*DW-1:DW]);
        end
        fifo_deq_data = {(fq.size() > 1) ? fq[1] : 32'h0, (fq.size() > 0) ? fq[0] : 32'h0};
        fifo_full     = (fq.size() >= DEPTH);
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: expected FIFO contents in order and the round-robin favourite.
    logic [DW-1:0] exp_q[$];
    bit            m_rr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit av, input bit bv, input bit ordy, input bit fl);
        a_valid   = av;
        b_valid   = bv;
        out_ready = ordy;
        flush_req = fl;
        a_data    = $urandom;
        b_data    = $urandom;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rr = 1'b0;
    endtask

    // Checks this cycle's grants and offered words, then advances the model past the coming edge.
    task automatic eval_cycle(input string tag);
        int slots;
        bit ea, eb, both;
        #1;
        slots = (DEPTH - 2) - exp_q.size();
        both  = a_valid && b_valid;
        ea = 1'b0;
        eb = 1'b0;
        if (both) begin
            if (slots >= 2) begin ea = 1'b1; eb = 1'b1; end
            else if (slots == 1) begin ea = !m_rr; eb = m_rr; end
        end else if (a_valid) begin
            ea = (slots >= 1);
        end else if (b_valid) begin
            eb = (slots >= 1);
        end
        check({tag, "/a_ready"}, 64'(a_ready), 64'(ea));
        check({tag, "/b_ready"}, 64'(b_ready), 64'(eb));
        check({tag, "/occupancy"}, 64'(occupancy), 64'(exp_q.size()));
        if (exp_q.size() >= 2) check({tag, "/pair_valid"}, 64'(out_valid), 64'd1);
        if (exp_q.size() == 0) check({tag, "/idle_valid"}, 64'(out_valid), 64'd0);
        if (out_valid) begin
            check({tag, "/out_cnt_range"},
                  64'((out_cnt != 2'd0) && (int'(out_cnt) <= exp_q.size())), 64'd1);
            if (exp_q.size() > 0) check({tag, "/word0"}, 64'(out_data[DW-1:0]), 64'(exp_q[0]));
            if (out_cnt == 2'd2 && exp_q.size() > 1)
                check({tag, "/word1"}, 64'(out_data[2*DW-1:DW]), 64'(exp_q[1]));
        end
        if (out_valid && out_ready)
            for (int k = 0; k < int'(out_cnt) && exp_q.size() > 0; k++) void'(exp_q.pop_front());
        if (ea && eb) begin
            if (m_rr) begin exp_q.push_back(b_data); exp_q.push_back(a_data); end
            else      begin exp_q.push_back(a_data); exp_q.push_back(b_data); end
            m_rr = !m_rr;
        end else if (ea) begin
            exp_q.push_back(a_data);
            m_rr = both ? !m_rr : 1'b1;
        end else if (eb) begin
            exp_q.push_back(b_data);
            m_rr = both ? !m_rr : 1'b0;
        end
    endtask

    initial begin
        drive(0, 0, 0, 0);
        a_valid0   = 1'b0;
        out_ready0 = 1'b0;
        model_reset();

        // Reset: outputs quiet even with requesters valid.
        repeat (2) step();
        drive(1, 1, 0, 0);
        #1;
        check("rst/a_ready", 64'(a_ready), 64'd0);
        check("rst/b_ready", 64'(b_ready), 64'd0);
        check("rst/enq_en", 64'(fifo_enq_en), 64'd0);
        check("rst/out_valid", 64'(out_valid), 64'd0);
        check("rst/occupancy", 64'(occupancy), 64'd0);
        step();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        eval_cycle("idle");

        // TIMEOUT = 0: a lone word is offered straight away.
        step();
        a_valid0 = 1'b1;
        drive(0, 0, 0, 0);
        eval_cycle("t5");
        step();
        a_valid0 = 1'b0;
        drive(0, 0, 0, 0);
        eval_cycle("t5");
        check("t5/out_valid0", 64'(out_valid0), 64'd1);
        check("t5/out_cnt0", 64'(out_cnt0), 64'd1);
        check("t5/occupancy0", 64'(occupancy0), 64'd1);
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
        drive(0, 0, 0, 0);
        eval_cycle("t5");
        check("t5/drained0", 64'({out_valid0, occupancy0}), 64'd0);

        // Both valid every cycle: lane0 alternates A, B, A, ...
        for (int i = 0; i < 20; i++) begin
            step();
            drive(1, 1, 1, 0);
            a_data = {16'hAAAA, 16'(i)};
            b_data = {16'hBBBB, 16'(i)};
            eval_cycle("t2");
            check("t2/lane0_src", 64'(fifo_enq_data[31:16]), (i % 2 == 0) ? 64'hAAAA : 64'hBBBB);
            if (i >= 1) check("t2/out_cnt", 64'(out_cnt), 64'd2);
        end

        // Mid-burst reset.
        step();
        drive(1, 1, 1, 0);
        reset = 1'b0;
        #1;
        check("t1/out_valid", 64'(out_valid), 64'd0);
        check("t1/occupancy", 64'(occupancy), 64'd0);
        check("t1/a_ready", 64'(a_ready), 64'd0);
        model_reset();
        step();
        reset = 1'b1;
        drive(1, 1, 0, 0);
        eval_cycle("t1_post");

        // Fill with out_ready low: odd count forces a single rr grant at 13, then stop at 14.
        step();
        drive(1, 0, 0, 0);
        eval_cycle("t3");
        for (int i = 0; i < 8; i++) begin
            step();
            drive(1, 1, 0, 0);
            eval_cycle("t3");
        end
        check("t3/occupancy_cap", 64'(occupancy), 64'd14);
        check("t3/no_grant", 64'({a_ready, b_ready}), 64'd0);
        for (int i = 0; i < 30; i++) begin
            step();
            drive(0, 0, 1, 0);
            eval_cycle("t3_drain");
        end
        check("t3/drained", 64'(occupancy), 64'd0);

        // Lone word: 8 HOLD cycles, then FLUSH held through a late partner, then flush_req.
        step();
        reset = 1'b0;
        model_reset();
        step();
        reset = 1'b1;
        drive(1, 0, 0, 0);
        eval_cycle("t4");
        for (int k = 0; k < TIMEOUT; k++) begin
            step();
            drive(0, 0, 0, 0);
            eval_cycle("t4");
            check("t4/hold_quiet", 64'(out_valid), 64'd0);
        end
        step();
        drive(0, 1, 0, 0);
        eval_cycle("t4");
        check("t4/flush_valid", 64'(out_valid), 64'd1);
        check("t4/flush_cnt", 64'(out_cnt), 64'd1);
        step();
        drive(0, 0, 1, 0);
        eval_cycle("t4");
        check("t4/flush_held_cnt", 64'(out_cnt), 64'd1);
        check("t4/flush_held_occ", 64'(occupancy), 64'd2);
        step();
        drive(0, 0, 0, 1);
        eval_cycle("t4");
        check("t4/rehold_valid", 64'(out_valid), 64'd0);
        check("t4/rehold_occ", 64'(occupancy), 64'd1);
        step();
        drive(0, 0, 1, 0);
        eval_cycle("t4");
        check("t4/req_flush_valid", 64'(out_valid), 64'd1);
        check("t4/req_flush_cnt", 64'(out_cnt), 64'd1);
        step();
        drive(0, 0, 0, 0);
        eval_cycle("t4");
        check("t4/empty", 64'({out_valid, occupancy}), 64'd0);

        // Random streaming through the wrap point with random backpressure.
        for (int i = 0; i < 500; i++) begin
            step();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            eval_cycle("t6");
        end
        for (int i = 0; i < 40; i++) begin
            step();
            drive(0, 0, 1, 0);
            eval_cycle("t6_drain");
        end
        check("t6/final_occ", 64'(occupancy), 64'd0);
        check("t6/final_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
